// File: rtl/reg8_file_if.sv
// Register-file access bundle: two read ports, accumulator/flag taps,
// byte write, pair read/write and the Z80 exchange strobes.
interface reg8_file_if;
  logic [2:0]  rd_a_sel;
  logic [7:0]  rd_a_data;
  logic [2:0]  rd_b_sel;
  logic [7:0]  rd_b_data;
  logic [7:0]  acc_out;
  logic [7:0]  flags_out;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        flags_wr_en;
  logic [7:0]  flags_wr_data;
  logic [1:0]  pair_sel;
  logic [15:0] pair_out;
  logic        pair_wr_en;
  logic [15:0] pair_wr_data;
  logic        ex_af;
  logic        exx;
  logic        ex_de_hl;
  logic [1:0]  bank_state;

  // Master drives selects, strobes and write data; observes the read side.
  modport master (
    output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data,
           flags_wr_en, flags_wr_data, pair_sel, pair_wr_en, pair_wr_data,
           ex_af, exx, ex_de_hl,
    input  rd_a_data, rd_b_data, acc_out, flags_out, pair_out, bank_state
  );

  // The register file itself.
  modport slave (
    input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data,
           flags_wr_en, flags_wr_data, pair_sel, pair_wr_en, pair_wr_data,
           ex_af, exx, ex_de_hl,
    output rd_a_data, rd_b_data, acc_out, flags_out, pair_out, bank_state
  );
endinterface

// File: rtl/reg8_file.sv
// Z80 8-bit register file: main and primed banks of B,C,D,E,H,L plus two
// A/F pairs, with EX AF,AF' / EXX bank toggles and an in-bank EX DE,HL swap.
// Reads are combinational from the active bank; all updates land on the
// rising edge with no write-to-read bypass.
module reg8_file (
  input  logic       clk,
  input  logic       reset_n,
  reg8_file_if.slave bus
);

  localparam logic [2:0] SEL_B   = 3'd0;
  localparam logic [2:0] SEL_C   = 3'd1;
  localparam logic [2:0] SEL_D   = 3'd2;
  localparam logic [2:0] SEL_E   = 3'd3;
  localparam logic [2:0] SEL_H   = 3'd4;
  localparam logic [2:0] SEL_L   = 3'd5;
  localparam logic [2:0] SEL_MEM = 3'd6;
  localparam logic [2:0] SEL_A   = 3'd7;

  localparam logic [1:0] PAIR_BC = 2'd0;
  localparam logic [1:0] PAIR_DE = 2'd1;
  localparam logic [1:0] PAIR_HL = 2'd2;
  localparam logic [1:0] PAIR_AF = 2'd3;

  localparam logic [7:0] RESET_BYTE = 8'hFF;

  // One bank of general registers, index 0..5 = B,C,D,E,H,L.
  typedef logic [5:0][7:0] bank_t;

  bank_t      gpr_q [2];
  logic [7:0] a_q   [2];
  logic [7:0] f_q   [2];
  logic       main_bank_q;
  logic       af_bank_q;

  bank_t      act_gpr;
  logic [7:0] act_a;
  logic [7:0] act_f;

  bank_t      gpr_nxt;
  logic [7:0] a_nxt;
  logic [7:0] f_nxt;

  // Byte read through the r-field; (HL) has no register behind it and
  // reads as all ones so the datapath sees a benign value.
  function automatic logic [7:0] read_sel(input logic [2:0]  sel,
                                          input bank_t       gpr,
                                          input logic [7:0]  acc);
    logic [7:0] val;
    case (sel)
      SEL_B:   val = gpr[0];
      SEL_C:   val = gpr[1];
      SEL_D:   val = gpr[2];
      SEL_E:   val = gpr[3];
      SEL_H:   val = gpr[4];
      SEL_L:   val = gpr[5];
      SEL_MEM: val = RESET_BYTE;
      default: val = acc;
    endcase
    return val;
  endfunction

  // Pair view of the active registers, high byte in [15:8].
  function automatic logic [15:0] read_pair(input logic [1:0] sel,
                                            input bank_t      gpr,
                                            input logic [7:0] acc,
                                            input logic [7:0] flg);
    logic [15:0] val;
    case (sel)
      PAIR_BC: val = {gpr[0], gpr[1]};
      PAIR_DE: val = {gpr[2], gpr[3]};
      PAIR_HL: val = {gpr[4], gpr[5]};
      default: val = {acc, flg};
    endcase
    return val;
  endfunction

  assign act_gpr = gpr_q[main_bank_q];
  assign act_a   = a_q[af_bank_q];
  assign act_f   = f_q[af_bank_q];

  assign bus.rd_a_data  = read_sel(bus.rd_a_sel, act_gpr, act_a);
  assign bus.rd_b_data  = read_sel(bus.rd_b_sel, act_gpr, act_a);
  assign bus.acc_out    = act_a;
  assign bus.flags_out  = act_f;
  assign bus.pair_out   = read_pair(bus.pair_sel, act_gpr, act_a, act_f);
  assign bus.bank_state = {main_bank_q, af_bank_q};

  // Next contents of the currently active registers. Later statements win:
  // byte write and flag write first, pair write over both, then the
  // DE/HL swap acts on the already-written values of the same bank.
  always_comb begin
    gpr_nxt = act_gpr;
    a_nxt   = act_a;
    f_nxt   = act_f;

    if (bus.wr_en) begin
      case (bus.wr_sel)
        SEL_B:   gpr_nxt[0] = bus.wr_data;
        SEL_C:   gpr_nxt[1] = bus.wr_data;
        SEL_D:   gpr_nxt[2] = bus.wr_data;
        SEL_E:   gpr_nxt[3] = bus.wr_data;
        SEL_H:   gpr_nxt[4] = bus.wr_data;
        SEL_L:   gpr_nxt[5] = bus.wr_data;
        SEL_A:   a_nxt      = bus.wr_data;
        default: ;
      endcase
    end

    if (bus.flags_wr_en) begin
      f_nxt = bus.flags_wr_data;
    end

    if (bus.pair_wr_en) begin
      case (bus.pair_sel)
        PAIR_BC: begin
          gpr_nxt[0] = bus.pair_wr_data[15:8];
          gpr_nxt[1] = bus.pair_wr_data[7:0];
        end
        PAIR_DE: begin
          gpr_nxt[2] = bus.pair_wr_data[15:8];
          gpr_nxt[3] = bus.pair_wr_data[7:0];
        end
        PAIR_HL: begin
          gpr_nxt[4] = bus.pair_wr_data[15:8];
          gpr_nxt[5] = bus.pair_wr_data[7:0];
        end
        default: begin
          a_nxt = bus.pair_wr_data[15:8];
          f_nxt = bus.pair_wr_data[7:0];
        end
      endcase
    end

    if (bus.ex_de_hl) begin
      gpr_nxt[2] = gpr_nxt[4];
      gpr_nxt[3] = gpr_nxt[5];
      gpr_nxt[4] = (bus.pair_wr_en && bus.pair_sel == PAIR_DE) ? bus.pair_wr_data[15:8]
                 : (bus.wr_en && bus.wr_sel == SEL_D) ? bus.wr_data : act_gpr[2];
      gpr_nxt[5] = (bus.pair_wr_en && bus.pair_sel == PAIR_DE) ? bus.pair_wr_data[7:0]
                 : (bus.wr_en && bus.wr_sel == SEL_E) ? bus.wr_data : act_gpr[3];
    end
  end

  // Storage: updated values go back into the bank that was active before
  // the edge; bank selects toggle afterwards, so an exchange never moves data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpr_q[0]    <= '1;
      gpr_q[1]    <= '1;
      a_q[0]      <= RESET_BYTE;
      a_q[1]      <= RESET_BYTE;
      f_q[0]      <= RESET_BYTE;
      f_q[1]      <= RESET_BYTE;
      main_bank_q <= 1'b0;
      af_bank_q   <= 1'b0;
    end else begin
      gpr_q[main_bank_q] <= gpr_nxt;
      a_q[af_bank_q]     <= a_nxt;
      f_q[af_bank_q]     <= f_nxt;
      main_bank_q        <= main_bank_q ^ bus.exx;
      af_bank_q          <= af_bank_q ^ bus.ex_af;
    end
  end

endmodule

// File: tb/tb_reg8_file.sv
// Bench for reg8_file: directed scenarios followed by randomized traffic,
// all checked against a pair-oriented behavioural model of the register set.
module tb_reg8_file;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  reg8_file_if bus ();

  reg8_file dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each main bank holds three 16-bit words BC, DE, HL; each AF bank
  // holds one 16-bit word with A high.
  logic [15:0] m_pair [2][3];
  logic [15:0] m_af   [2];
  int          m_mb;
  int          m_ab;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 3; p++) m_pair[b][p] = 16'hFFFF;
      m_af[b] = 16'hFFFF;
    end
    m_mb = 0;
    m_ab = 0;
  endtask

  function automatic logic [7:0] model_reg(input logic [2:0] sel);
    logic [15:0] w;
    int s;
    s = int'(sel);
    if (s == 6) return 8'hFF;
    if (s == 7) w = m_af[m_ab];
    else        w = m_pair[m_mb][s / 2];
    return ((s % 2) == 0 || s == 7) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] model_pair(input logic [1:0] sel);
    if (sel == 2'd3) return m_af[m_ab];
    return m_pair[m_mb][int'(sel)];
  endfunction

  // One clock edge of the architecture, from the inputs present at the edge.
  task automatic model_update();
    logic [15:0] p [3];
    logic [15:0] af;
    logic [15:0] tmp;
    int s;
    for (int i = 0; i < 3; i++) p[i] = m_pair[m_mb][i];
    af = m_af[m_ab];
    if (bus.wr_en) begin
      s = int'(bus.wr_sel);
      if (s < 6) begin
        if ((s % 2) == 0) p[s / 2][15:8] = bus.wr_data;
        else              p[s / 2][7:0]  = bus.wr_data;
      end else if (s == 7) begin
        af[15:8] = bus.wr_data;
      end
    end
    if (bus.flags_wr_en) af[7:0] = bus.flags_wr_data;
    if (bus.pair_wr_en) begin
      if (bus.pair_sel == 2'd3) af = bus.pair_wr_data;
      else                      p[int'(bus.pair_sel)] = bus.pair_wr_data;
    end
    if (bus.ex_de_hl) begin
      tmp  = p[1];
      p[1] = p[2];
      p[2] = tmp;
    end
    for (int i = 0; i < 3; i++) m_pair[m_mb][i] = p[i];
    m_af[m_ab] = af;
    if (bus.exx)   m_mb = 1 - m_mb;
    if (bus.ex_af) m_ab = 1 - m_ab;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("rd_a",   {8'h00, bus.rd_a_data}, {8'h00, model_reg(bus.rd_a_sel)});
    chk("rd_b",   {8'h00, bus.rd_b_data}, {8'h00, model_reg(bus.rd_b_sel)});
    chk("acc",    {8'h00, bus.acc_out},   {8'h00, model_reg(3'd7)});
    chk("flags",  {8'h00, bus.flags_out}, {8'h00, m_af[m_ab][7:0]});
    chk("pair",   bus.pair_out,           model_pair(bus.pair_sel));
    chk("banks",  {14'h0, bus.bank_state}, {14'h0, 1'(m_mb), 1'(m_ab)});
  endtask

  task automatic idle();
    bus.wr_en        = 1'b0;
    bus.wr_sel       = 3'd0;
    bus.wr_data      = 8'h00;
    bus.flags_wr_en  = 1'b0;
    bus.flags_wr_data = 8'h00;
    bus.pair_wr_en   = 1'b0;
    bus.pair_wr_data = 16'h0000;
    bus.ex_af        = 1'b0;
    bus.exx          = 1'b0;
    bus.ex_de_hl     = 1'b0;
  endtask

  // Check pre-edge outputs, take the edge, advance the model.
  task automatic step();
    #3;
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.rd_a_sel = 3'd0;
    bus.rd_b_sel = 3'd0;
    bus.pair_sel = 2'd0;
    idle();
    model_reset();
    reset_n = 1'b0;

    // Reset state, with strobes active to show they are ignored.
    bus.wr_en = 1'b1; bus.wr_sel = 3'd7; bus.wr_data = 8'h00; bus.exx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc",   {8'h00, bus.acc_out},   16'h00FF);
    chk("rst_flags", {8'h00, bus.flags_out}, 16'h00FF);
    chk("rst_banks", {14'h0, bus.bank_state}, 16'h0000);
    idle();
    reset_n = 1'b1;

    // All registers and pairs read FF after release.
    for (int s = 0; s < 8; s++) begin
      bus.rd_a_sel = 3'(s);
      bus.rd_b_sel = 3'(7 - s);
      bus.pair_sel = 2'(s);
      #1;
      chk("init_rd_a", {8'h00, bus.rd_a_data}, 16'h00FF);
      chk("init_rd_b", {8'h00, bus.rd_b_data}, 16'h00FF);
      chk("init_pair", bus.pair_out, 16'hFFFF);
    end
    @(posedge clk);
    #1;

    // D=12, H=34, then EX DE,HL with D/H on the read ports.
    bus.rd_a_sel = 3'd2; bus.rd_b_sel = 3'd4;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd2; bus.wr_data = 8'h12;
    step();
    bus.wr_sel = 3'd4; bus.wr_data = 8'h34;
    step();
    idle(); bus.ex_de_hl = 1'b1;
    #3;
    chk("xdh_pre_d", {8'h00, bus.rd_a_data}, 16'h0012);
    #1;
    step();
    idle();
    #1;
    chk("xdh_d", {8'h00, bus.rd_a_data}, 16'h0034);
    chk("xdh_h", {8'h00, bus.rd_b_data}, 16'h0012);

    // B=AA, EXX, B=55, EXX back.
    bus.rd_a_sel = 3'd0;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd0; bus.wr_data = 8'hAA;
    step();
    idle(); bus.exx = 1'b1;
    step();
    idle(); bus.wr_en = 1'b1; bus.wr_sel = 3'd0; bus.wr_data = 8'h55;
    step();
    idle();
    #1;
    chk("exx_b_alt", {8'h00, bus.rd_a_data}, 16'h0055);
    chk("exx_banks", {14'h0, bus.bank_state}, 16'h0002);
    bus.exx = 1'b1;
    step();
    idle();
    #1;
    chk("exx_b_main", {8'h00, bus.rd_a_data}, 16'h00AA);

    // A=3C, F=81 together, then EX AF,AF' twice.
    bus.wr_en = 1'b1; bus.wr_sel = 3'd7; bus.wr_data = 8'h3C;
    bus.flags_wr_en = 1'b1; bus.flags_wr_data = 8'h81;
    step();
    idle(); bus.ex_af = 1'b1;
    step();
    idle();
    #1;
    chk("exaf_acc_alt",   {8'h00, bus.acc_out},   16'h00FF);
    chk("exaf_flags_alt", {8'h00, bus.flags_out}, 16'h00FF);
    bus.ex_af = 1'b1;
    step();
    idle();
    #1;
    chk("exaf_acc",   {8'h00, bus.acc_out},   16'h003C);
    chk("exaf_flags", {8'h00, bus.flags_out}, 16'h0081);

    // Pair write beats byte write; (HL) write changes nothing.
    bus.rd_a_sel = 3'd4; bus.rd_b_sel = 3'd5; bus.pair_sel = 2'd2;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd5; bus.wr_data = 8'h11;
    bus.pair_wr_en = 1'b1; bus.pair_wr_data = 16'hBEEF;
    step();
    idle();
    #1;
    chk("pw_h", {8'h00, bus.rd_a_data}, 16'h00BE);
    chk("pw_l", {8'h00, bus.rd_b_data}, 16'h00EF);
    bus.wr_en = 1'b1; bus.wr_sel = 3'd6; bus.wr_data = 8'h00;
    step();
    idle();
    for (int p = 0; p < 4; p++) begin
      bus.pair_sel = 2'(p);
      #1;
      chk("mem_wr_pair", bus.pair_out, model_pair(bus.pair_sel));
    end
    @(posedge clk);
    #1;

    // Pair AF write beats flag write.
    bus.flags_wr_en = 1'b1; bus.flags_wr_data = 8'h00;
    bus.pair_wr_en = 1'b1; bus.pair_sel = 2'd3; bus.pair_wr_data = 16'h5AC3;
    step();
    idle();
    #1;
    chk("af_pw_flags", {8'h00, bus.flags_out}, 16'h00C3);
    chk("af_pw_acc",   {8'h00, bus.acc_out},   16'h005A);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.rd_a_sel      = 3'($urandom_range(0, 7));
      bus.rd_b_sel      = 3'($urandom_range(0, 7));
      bus.pair_sel      = 2'($urandom_range(0, 3));
      bus.wr_en         = 1'($urandom_range(0, 1));
      bus.wr_sel        = 3'($urandom_range(0, 7));
      bus.wr_data       = 8'($urandom);
      bus.flags_wr_en   = ($urandom_range(0, 3) == 0);
      bus.flags_wr_data = 8'($urandom);
      bus.pair_wr_en    = ($urandom_range(0, 3) == 0);
      bus.pair_wr_data  = 16'($urandom);
      bus.ex_af         = ($urandom_range(0, 3) == 0);
      bus.exx           = ($urandom_range(0, 3) == 0);
      bus.ex_de_hl      = ($urandom_range(0, 3) == 0);
      step();
    end
    idle();
    #1;

    // Asynchronous reset mid-cycle with a write pending.
    bus.rd_a_sel = 3'd0;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd0; bus.wr_data = 8'h5A; bus.exx = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_acc",   {8'h00, bus.acc_out},   16'h00FF);
    chk("arst_flags", {8'h00, bus.flags_out}, 16'h00FF);
    chk("arst_banks", {14'h0, bus.bank_state}, 16'h0000);
    chk("arst_b",     {8'h00, bus.rd_a_data}, 16'h00FF);
    @(posedge clk);
    #1;
    chk("arst_hold_b", {8'h00, bus.rd_a_data}, 16'h00FF);
    idle();
    reset_n = 1'b1;
    step();
    chk("arst_after_b", {8'h00, bus.rd_a_data}, 16'h00FF);
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg8_file.md
REG8_FILE -- requirements
Module: reg8_file

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 rd_a_sel  in  3  read port A select, Z80 r-field: B=0 C=1 D=2 E=3 H=4 L=5 (HL)=6 A=7.
REQ-004 rd_a_data  out  8  combinational contents of rd_a_sel register.
REQ-005 rd_b_sel  in  3  read port B select, same encoding.
REQ-006 rd_b_data  out  8  combinational contents of rd_b_sel register.
REQ-007 acc_out  out  8  active A; feeds the 8-bit ALU accumulator input.
REQ-008 flags_out  out  8  active F, layout S Z F5 H F3 PV N C (bit 7..0); feeds the ALU flag input.
REQ-009 wr_en  in  1  8-bit register write strobe.
REQ-010 wr_sel  in  3  8-bit write target, r-field encoding.
REQ-011 wr_data  in  8  8-bit write data (ALU result).
REQ-012 flags_wr_en  in  1  F write strobe.
REQ-013 flags_wr_data  in  8  F write data (ALU flag result).
REQ-014 pair_sel  in  2  pair select: BC=0 DE=1 HL=2 AF=3.
REQ-015 pair_out  out  16  combinational contents of selected pair, high byte first (AF: A in [15:8]).
REQ-016 pair_wr_en  in  1  16-bit pair write strobe.
REQ-017 pair_wr_data  in  16  pair write data.
REQ-018 ex_af  in  1  one-cycle pulse: EX AF,AF'.
REQ-019 exx  in  1  one-cycle pulse: EXX (swap BC/DE/HL with primed set).
REQ-020 ex_de_hl  in  1  one-cycle pulse: EX DE,HL in active bank.
REQ-021 bank_state  out  2  {main_bank, af_bank} current bank selects, debug/verification.

Function
REQ-022 Storage SHALL be two banks of B,C,D,E,H,L, two A and two F registers, plus bank-select flops af_bank and main_bank.
REQ-023 Reads SHALL be combinational from active bank; sel=6 SHALL return 8'hFF.
REQ-024 Writes SHALL take effect at the next rising edge; same-cycle reads return pre-write value (no bypass).
REQ-025 wr_sel=6 with wr_en SHALL be ignored (no state change).
REQ-026 wr_sel=7 SHALL write active A; flags_wr_en SHALL write active F independently of wr_en in the same cycle.
REQ-027 pair_wr_en SHALL write both bytes of selected pair in active bank(s); pair AF uses af_bank.
REQ-028 8-bit write and pair write to the same byte in one cycle: pair write SHALL win.
REQ-029 flags_wr_en and pair_wr_en with pair_sel=3 in one cycle: pair write SHALL win for F.
REQ-030 Per-cycle order SHALL be: apply writes to pre-edge active bank, then ex_de_hl, then exx/ex_af bank toggles.
REQ-031 ex_de_hl SHALL physically swap D<->H and E<->L within the pre-edge active main bank.
REQ-032 exx SHALL toggle main_bank; ex_af SHALL toggle af_bank; no data movement.
REQ-033 Simultaneous exx and ex_de_hl: swap SHALL occur in the old bank, then main_bank toggles.
REQ-034 Simultaneous ex_af and exx SHALL toggle both bank selects in the same edge.
REQ-035 Strobes held high N cycles SHALL act N times (level-sensitive per cycle, no edge detect).

Reset
REQ-036 reset_n low SHALL asynchronously set all 16 data registers to 8'hFF and af_bank=main_bank=0.
REQ-037 During reset all write and exchange strobes SHALL be ignored; acc_out=8'hFF, flags_out=8'hFF, bank_state=2'b00.
REQ-038 Reset asserted mid-operation SHALL discard any pending write of that cycle; first update on first rising edge after release.

Verification
REQ-039 Reset release, no strobes -> rd_a_data=FF for all sel, pair_out=FFFF for all pairs, bank_state=00.
REQ-040 wr_en sel=2 data=12, next cycle wr_en sel=4 data=34; then ex_de_hl -> D reads 34, H reads 12; same cycle as ex_de_hl rd_a_sel=2 still 34? (pre-edge: D=12 shown, after edge 34).
REQ-041 Write B=AA, exx, write B=55 -> B reads 55, bank_state=10; exx again -> B reads AA.
REQ-042 wr_en sel=7 data=3C and flags_wr_en data=81 same cycle, then ex_af -> acc_out=FF flags_out=FF; ex_af -> acc_out=3C flags_out=81.
REQ-043 Same cycle: wr_en sel=5 data=11, pair_wr_en pair_sel=2 data=BEEF -> H=BE, L=EF; wr_en sel=6 data=00 -> no register changes.
REQ-044 Assert reset_n low asynchronously mid-cycle with wr_en high -> outputs FF immediately, bank_state=00, written value absent after release.
